ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
Multi-cycle block-transfer engine for LDM/STM instructions. It is the initiator side of the register file's ports: it drives the read select, consumes combinational read data, and drives the write port (enable/select/data). It sequences one memory beat per listed register over a req/ack memory interface, then optionally writes back the base register. The control unit starts it and stalls on busy.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, register/memory data width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin transfer; sampled only in IDLE
is_load  in  1  1=LDM, 0=STM
pre_index  in  1  1=increment/decrement before each beat (IB/DB)
up  in  1  1=ascending addresses (IA/IB), 0=descending (DA/DB)
writeback  in  1  write updated base to base_reg at end
base_reg  in  4  base register number
reg_list  in  16  bit i set = transfer register i
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
read_reg_sel  out  4  register file read select
read_reg_data  in  DATA_W  register file read data, combinational from read_reg_sel
reg_write_enable  out  1  register file write enable
write_reg_sel  out  4  register file write select
write_reg_data  out  DATA_W  register file write data
mem_req  out  1  memory beat request
mem_we  out  1  1=write (STM), 0=read (LDM)
mem_addr  out  ADDR_W  word address of beat
mem_wdata  out  DATA_W  store data
mem_ack  in  1  beat accepted/completed this cycle
mem_rdata  in  DATA_W  load data, valid when mem_ack=1

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE.
  - All outputs 0, including busy, done, mem_req, reg_write_enable, read_reg_sel and mem_addr.
  - An in-flight beat is abandoned; mem_req drops the next cycle. Applies mid-operation identically.
- States: IDLE, BASE, XFER, LWR, WB, DONE.
- IDLE:
  - On start=1, latch is_load, pre_index, up, writeback, base_reg and reg_list; go to BASE.
  - start while not IDLE is ignored.
- busy: 1 in every state except IDLE.
- BASE (1 cycle):
  - read_reg_sel=base_reg; latch read_reg_data as base; compute n = popcount(reg_list).
  - First address: IA=base, IB=base+4, DA=base-4n+4, DB=base-4n.
  - Final base: up ? base+4n : base-4n. Arithmetic is mod 2^ADDR_W, so wrap is silent.
  - If n=0, go to DONE: no beats, no writeback.
- Beat order is ascending register number at ascending addresses, regardless of up. Address increments by 4 per beat.
- XFER:
  - mem_req=1 with mem_addr and mem_we=~is_load.
  - For STM, read_reg_sel=current register and mem_wdata=read_reg_data.
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until a cycle with mem_ack=1.
  - STM ack: advance to the next set bit. The next beat's request is presented the following cycle, so mem_req stays high back-to-back.
  - LDM ack: capture mem_rdata and go to LWR.
- LWR (1 cycle):
  - reg_write_enable=1, write_reg_sel=current register, write_reg_data=captured data; mem_req=0.
  - Then go to XFER for the next register, or leave after the last one.
- After the last beat: go to WB if writeback=1, else DONE.
  - Exception: for LDM with base_reg in reg_list, writeback is suppressed and the loaded value stands.
- WB (1 cycle): reg_write_enable=1, write_reg_sel=base_reg, write_reg_data=final base.
- STM with base_reg in reg_list stores the original base value (writeback occurs after all beats).
- R15 is treated as an ordinary register; this block has no PC/branch semantics.
- DONE (1 cycle): done=1, busy=1; next state IDLE. start is accepted again on the cycle after DONE.
- reg_write_enable is asserted only in LWR and WB. At most one register write occurs per cycle.
- Latency with zero-wait ack:
  - STM: 1 (BASE) + n + wb + 1 (DONE) cycles.
  - LDM: 1 + 2n + wb + 1 cycles.

Test Plan:
- STMIA r0!, {r1,r2,r4}; r0=0x1000, r1=0x11, r2=0x22, r4=0x44; ack tied 1 -> beats at 0x1000/0x1004/0x1008 with wdata 0x11/0x22/0x44 on consecutive cycles. r0=0x100C after WB. Single done pulse. Total 6 cycles.
- LDMDB r13!, {r4,r5}; r13=0x2000; mem returns 0xA at 0x1FF8 and 0xB at 0x1FFC -> r4=0xA, r5=0xB, r13=0x1FF8.
- LDMIA r2!, {r1,r2}; r2=0x3000; mem returns 0x5, 0x6 -> r1=0x5, r2=0x6. No WB write occurs.
- STMDA r3, {r7}; r3=0x10; mem_ack delayed 3 cycles -> mem_req, mem_addr=0x10 and mem_wdata stay stable for 4 cycles. r3 unchanged.
- reg_list=0 with writeback=1 -> no mem_req, no reg write, done 2 cycles after start.
- reset=0 during 3rd beat of a 5-register LDM -> next cycle all outputs 0 and state IDLE. A new start then runs cleanly. A start pulsed while busy=1 has no effect.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ldm_stm_sequencer
//  Purpose  : Multi-cycle LDM/STM block-transfer engine. Reads the base
//             register, issues one memory beat per listed register (lowest
//             register at lowest address), writes loaded data back to the
//             register file and optionally updates the base register.
//  Ports    : clk / reset           - clock, synchronous active-low reset
//             start, is_load, pre_index, up, writeback, base_reg, reg_list
//                                   - instruction decode, sampled in IDLE
//             busy, done            - status to the control unit
//             read_reg_sel/_data    - register file read port (comb. data)
//             reg_write_enable, write_reg_sel, write_reg_data
//                                   - register file write port
//             mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata
//                                   - req/ack memory beat interface
//  Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre_index,
    input  logic              up,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [15:0]       reg_list,
    output logic              busy,
    output logic              done,
    output logic [3:0]        read_reg_sel,
    input  logic [DATA_W-1:0] read_reg_data,
    output logic              reg_write_enable,
    output logic [3:0]        write_reg_sel,
    output logic [DATA_W-1:0] write_reg_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_BASE = 3'd1;
    localparam logic [2:0] c_XFER = 3'd2;
    localparam logic [2:0] c_LWR  = 3'd3;
    localparam logic [2:0] c_WB   = 3'd4;
    localparam logic [2:0] c_DONE = 3'd5;

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [3:0] f_lowest(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [4:0] f_popcount(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_is_load;
    logic              r_pre;
    logic              r_up;
    logic              r_wb;
    logic [3:0]        r_base_reg;
    logic              r_base_in_list;
    // Registers still to transfer; the current one stays set until its
    // beat (STM) or its register write (LDM) has completed.
    logic [15:0]       r_list;
    logic [3:0]        r_cur;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_final_base;
    logic [DATA_W-1:0] r_ldata;

    logic [4:0]        w_n;
    logic [ADDR_W-1:0] w_span_a;
    logic [DATA_W-1:0] w_span_d;
    logic [ADDR_W-1:0] w_base_a;
    logic [ADDR_W-1:0] w_first_addr;
    logic [DATA_W-1:0] w_final_base;
    logic [15:0]       w_rem_list;
    logic [3:0]        w_rem_next;
    logic              w_more;
    logic [2:0]        w_end_state;

    // Base-relative arithmetic; all of it wraps silently.
    always_comb begin
        w_n          = f_popcount(r_list);
        w_span_a     = ADDR_W'({w_n, 2'b00});
        w_span_d     = DATA_W'({w_n, 2'b00});
        w_base_a     = ADDR_W'(read_reg_data);
        w_final_base = r_up ? (read_reg_data + w_span_d) : (read_reg_data - w_span_d);
        case ({r_up, r_pre})
            2'b10:   w_first_addr = w_base_a;
            2'b11:   w_first_addr = w_base_a + ADDR_W'(4);
            2'b00:   w_first_addr = w_base_a - w_span_a + ADDR_W'(4);
            default: w_first_addr = w_base_a - w_span_a;
        endcase
    end

    // Remaining list once the current register is retired.
    always_comb begin
        w_rem_list  = r_list & ~(16'd1 << r_cur);
        w_rem_next  = f_lowest(w_rem_list);
        w_more      = |w_rem_list;
        // A loaded base register wins over the writeback value.
        w_end_state = (r_wb && !(r_is_load && r_base_in_list)) ? c_WB : c_DONE;
    end

    // Next state and outputs; everything defaults to 0 so IDLE is all-zero.
    always_comb begin
        w_next_state     = r_state;
        busy             = 1'b0;
        done             = 1'b0;
        read_reg_sel     = 4'd0;
        reg_write_enable = 1'b0;
        write_reg_sel    = 4'd0;
        write_reg_data   = '0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (r_state)
            c_IDLE: begin
                if (start) w_next_state = c_BASE;
            end
            c_BASE: begin
                busy         = 1'b1;
                read_reg_sel = r_base_reg;
                w_next_state = (w_n == 5'd0) ? c_DONE : c_XFER;
            end
            c_XFER: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = r_addr;
                mem_we   = ~r_is_load;
                if (!r_is_load) begin
                    read_reg_sel = r_cur;
                    mem_wdata    = read_reg_data;
                end
                if (mem_ack) begin
                    if (r_is_load) w_next_state = c_LWR;
                    else           w_next_state = w_more ? c_XFER : w_end_state;
                end
            end
            c_LWR: begin
                busy             = 1'b1;
                reg_write_enable = 1'b1;
                write_reg_sel    = r_cur;
                write_reg_data   = r_ldata;
                w_next_state     = w_more ? c_XFER : w_end_state;
            end
            c_WB: begin
                busy             = 1'b1;
                reg_write_enable = 1'b1;
                write_reg_sel    = r_base_reg;
                write_reg_data   = r_final_base;
                w_next_state     = c_DONE;
            end
            c_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= c_IDLE;
            r_is_load      <= 1'b0;
            r_pre          <= 1'b0;
            r_up           <= 1'b0;
            r_wb           <= 1'b0;
            r_base_reg     <= 4'd0;
            r_base_in_list <= 1'b0;
            r_list         <= 16'd0;
            r_cur          <= 4'd0;
            r_addr         <= '0;
            r_final_base   <= '0;
            r_ldata        <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_is_load      <= is_load;
                        r_pre          <= pre_index;
                        r_up           <= up;
                        r_wb           <= writeback;
                        r_base_reg     <= base_reg;
                        r_base_in_list <= reg_list[base_reg];
                        r_list         <= reg_list;
                    end
                end
                c_BASE: begin
                    r_addr       <= w_first_addr;
                    r_final_base <= w_final_base;
                    r_cur        <= f_lowest(r_list);
                end
                c_XFER: begin
                    if (mem_ack) begin
                        r_addr <= r_addr + ADDR_W'(4);
                        if (r_is_load) begin
                            r_ldata <= mem_rdata;
                        end else begin
                            r_list <= w_rem_list;
                            r_cur  <= w_rem_next;
                        end
                    end
                end
                c_LWR: begin
                    r_list <= w_rem_list;
                    r_cur  <= w_rem_next;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldm_stm_sequencer
//  Purpose  : Scoreboard bench for ldm_stm_sequencer. Hosts a register file
//             and a memory with a variable-latency responder; expected beats,
//             register writes and completion latency are predicted from the
//             instruction semantics when each transfer is issued.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_sequencer;

    logic        clk;
    logic        reset;
    logic        start, is_load, pre_index, up, writeback;
    logic [3:0]  base_reg;
    logic [15:0] reg_list;
    logic        busy, done;
    logic [3:0]  read_reg_sel;
    logic [31:0] read_reg_data;
    logic        reg_write_enable;
    logic [3:0]  write_reg_sel;
    logic [31:0] write_reg_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .pre_index(pre_index), .up(up), .writeback(writeback),
        .base_reg(base_reg), .reg_list(reg_list), .busy(busy), .done(done),
        .read_reg_sel(read_reg_sel), .read_reg_data(read_reg_data),
        .reg_write_enable(reg_write_enable), .write_reg_sel(write_reg_sel),
        .write_reg_data(write_reg_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct { logic [3:0] sel; logic [31:0] data; } wr_t;

    logic [31:0] rf [16];
    logic [31:0] mem [logic [31:0]];
    beat_t exp_beats[$];
    wr_t   exp_wr[$];
    int    exp_lat[$];

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, fixed_wait = 0, beats_seen = 0, req_cycles = 0;

    assign read_reg_data = rf[read_reg_sel];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5C3_0F1E;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: each beat waits fixed_wait cycles, or 0..3 at random.
    initial begin
        int tgt, waited;
        tgt = -1; waited = 0;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (!mem_req) begin
                mem_ack = 1'b0; tgt = -1;
            end else begin
                if (mem_ack || tgt < 0) begin
                    tgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                    waited = 0;
                end else begin
                    waited++;
                end
                mem_ack   = (waited >= tgt);
                mem_rdata = mem_ack ? mem_val(mem_addr) : 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: compares every beat, register write and done pulse.
    initial begin
        logic pend;
        logic [31:0] p_addr, p_wdata;
        logic p_we;
        beat_t b;
        wr_t w;
        int lat;
        pend = 1'b0; p_addr = '0; p_wdata = '0; p_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (mem_req) begin
                    req_cycles++;
                    if (pend) begin
                        chk("hold_addr", mem_addr, p_addr);
                        chk("hold_we", mem_we, p_we);
                        if (p_we) chk("hold_wdata", mem_wdata, p_wdata);
                    end
                end
                pend = mem_req && !mem_ack;
                p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
                if (mem_req && mem_ack) begin
                    beats_seen++;
                    if (exp_beats.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_beat: got addr 0x%0h expected none", mem_addr);
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_addr", mem_addr, b.addr);
                        chk("beat_we", mem_we, b.we);
                        if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
                    end
                    if (mem_we) mem[mem_addr] = mem_wdata;
                end
                if (reg_write_enable) begin
                    if (exp_wr.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_write: got r%0d expected none", write_reg_sel);
                    end else begin
                        w = exp_wr.pop_front();
                        chk("wr_sel", write_reg_sel, w.sel);
                        chk("wr_data", write_reg_data, w.data);
                    end
                    rf[write_reg_sel] = write_reg_data;
                end
                if (done) begin
                    chk("done_busy", busy, 1'b1);
                    if (exp_lat.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_done: got done expected none");
                    end else begin
                        lat = exp_lat.pop_front();
                        if (lat >= 0) chk("latency", cyc - start_cyc, lat);
                    end
                end
            end
        end
    end

    // Reference model: predicts the transfer from instruction semantics.
    task automatic predict(input logic ld, input logic pre, input logic upd,
                           input logic wb, input logic [3:0] base, input logic [15:0] list);
        int n, k;
        logic [31:0] b, low;
        n = $countones(list);
        b = rf[base];
        if (upd) low = pre ? b + 32'd4 : b;
        else     low = pre ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                exp_beats.push_back('{we: !ld, addr: low + 32'(4 * k), wdata: rf[i]});
                if (ld) exp_wr.push_back('{sel: 4'(i), data: mem_val(low + 32'(4 * k))});
                k++;
            end
        end
        if (n > 0 && wb && !(ld && list[base]))
            exp_wr.push_back('{sel: base, data: upd ? b + 32'(4 * n) : b - 32'(4 * n)});
        if (fixed_wait == 0)
            exp_lat.push_back(n == 0 ? 2 :
                              2 + n * (ld ? 2 : 1) + ((wb && !(ld && list[base])) ? 1 : 0));
        else
            exp_lat.push_back(-1);
    endtask

    task automatic issue(input logic ld, input logic pre, input logic upd, input logic wb,
                         input logic [3:0] base, input logic [15:0] list, input logic inject);
        predict(ld, pre, upd, wb, base, list);
        @(negedge clk);
        is_load = ld; pre_index = pre; up = upd; writeback = wb;
        base_reg = base; reg_list = list; start = 1'b1;
        start_cyc = cyc; beats_seen = 0; req_cycles = 0;
        @(negedge clk);
        if (inject) begin
            // Busy: this start must be ignored.
            chk("busy_in_base", busy, 1'b1);
            is_load = ~ld; up = ~upd; base_reg = base + 4'd1; reg_list = 16'hFFFF;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_lat.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("done_pending", exp_lat.size(), 0);
        chk("beats_left", exp_beats.size(), 0);
        chk("writes_left", exp_wr.size(), 0);
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_mem_req"}, mem_req, 1'b0);
        chk({tag, "_rwe"}, reg_write_enable, 1'b0);
        chk({tag, "_rsel"}, read_reg_sel, 4'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_wsel"}, write_reg_sel, 4'd0);
        chk({tag, "_wdata"}, write_reg_data, 32'd0);
    endtask

    initial begin
        logic found;
        logic [15:0] list;
        reset = 1'b0; start = 1'b0; is_load = 1'b0; pre_index = 1'b0; up = 1'b0;
        writeback = 1'b0; base_reg = 4'd0; reg_list = 16'd0;
        for (int r = 0; r < 16; r++) rf[r] = 32'h100 * r;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // STMIA r0!, {r1,r2,r4}
        fixed_wait = 0;
        rf[0] = 32'h1000; rf[1] = 32'h11; rf[2] = 32'h22; rf[4] = 32'h44;
        issue(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'h0016, 1'b0);
        wait_done();
        chk("stmia_r0", rf[0], 32'h100C);
        chk("stmia_mem8", mem_val(32'h1008), 32'h44);

        // LDMDB r13!, {r4,r5}
        rf[13] = 32'h2000; mem[32'h1FF8] = 32'hA; mem[32'h1FFC] = 32'hB;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 16'h0030, 1'b0);
        wait_done();
        chk("ldmdb_r4", rf[4], 32'hA);
        chk("ldmdb_r5", rf[5], 32'hB);
        chk("ldmdb_r13", rf[13], 32'h1FF8);

        // LDMIA r2!, {r1,r2}: base loaded, writeback suppressed
        rf[2] = 32'h3000; mem[32'h3000] = 32'h5; mem[32'h3004] = 32'h6;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 16'h0006, 1'b0);
        wait_done();
        chk("ldmia_r1", rf[1], 32'h5);
        chk("ldmia_r2", rf[2], 32'h6);

        // STMDA r3, {r7} with a 3-cycle ack delay
        fixed_wait = 3;
        rf[3] = 32'h10; rf[7] = 32'h77;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 16'h0080, 1'b0);
        wait_done();
        chk("stmda_req_cycles", req_cycles, 4);
        chk("stmda_r3", rf[3], 32'h10);
        chk("stmda_mem", mem_val(32'h10), 32'h77);

        // Empty list with writeback
        fixed_wait = 0;
        issue(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 16'h0000, 1'b0);
        wait_done();
        chk("empty_req_cycles", req_cycles, 0);

        // Reset during the 3rd beat of a 5-register LDM, with a busy start
        fixed_wait = 1;
        rf[0] = 32'h4000;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 16'h003E, 1'b1);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (beats_seen == 2 && mem_req) found = 1'b1;
        end
        chk("reach_beat3", found, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        exp_beats.delete(); exp_wr.delete(); exp_lat.delete();
        reset = 1'b1;
        issue(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 16'h0C01, 1'b0);
        wait_done();

        // Randomized transfers
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < 16; r++) rf[r] = $urandom;
            fixed_wait = ($urandom_range(0, 2) == 0) ? 0 : -1;
            list = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom & $urandom)
                                               : 16'($urandom);
            issue(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), list, ($urandom_range(0, 3) == 0) && (list != 16'd0));
            wait_done();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
